// File: rtl/trng_req_arbiter.sv
// Round-robin arbiter sharing one 8-bit TRNG stream among N_REQ consumers.
// Packs bytes into words, delivers on valid/ready, and blocks on repetition faults.
module trng_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WORD_W    = 32,
  parameter int REP_LIMIT = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [7:0]        trng_data,
  input  logic              trng_valid,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  rnd_ready,
  input  logic              fault_clr,
  output logic [N_REQ-1:0]  gnt,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  output logic              fault
);
  localparam int BYTES = WORD_W / 8;
  localparam int CW    = $clog2(BYTES + 1);
  localparam int PW    = $clog2(N_REQ);
  localparam int PW1   = PW + 1;
  localparam logic [CW-1:0]  LAST_BYTE = CW'(BYTES - 1);
  localparam logic [7:0]     REP_MAX   = 8'(REP_LIMIT);
  localparam logic [PW1-1:0] N_REQ_W   = PW1'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DELIVER = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [PW-1:0]     r_gidx, w_gidx_nxt, r_ptr, w_ptr_nxt, w_pick, w_gidx_inc;
  logic [PW1-1:0]    w_sum;
  logic              w_found;
  logic [WORD_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt, r_fault, w_fault_nxt;
  logic [CW-1:0]     r_bcnt, w_bcnt_nxt;
  logic [7:0]        r_rep, w_rep_nxt, w_rep_upd, r_last, w_last_nxt;
  logic              r_last_vld, w_last_vld_nxt;
  logic              w_trip;

  assign gnt       = r_gnt;
  assign rnd_data  = r_data;
  assign rnd_valid = r_valid;
  assign fault     = r_fault;

  assign w_gidx_inc = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);

  // First requesting index at or after the RR pointer, wrapping at N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + PW1'(i);
      if (w_sum >= N_REQ_W) begin
        w_sum = w_sum - N_REQ_W;
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[PW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state, health test and next values of every output register.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gidx_nxt     = r_gidx;
    w_ptr_nxt      = r_ptr;
    w_data_nxt     = r_data;
    w_valid_nxt    = r_valid;
    w_fault_nxt    = r_fault;
    w_bcnt_nxt     = r_bcnt;
    w_rep_nxt      = r_rep;
    w_last_nxt     = r_last;
    w_last_vld_nxt = r_last_vld;
    w_rep_upd      = 8'd1;
    w_trip         = 1'b0;

    if (trng_valid) begin
      if (r_last_vld && (trng_data == r_last)) begin
        w_rep_upd = (r_rep >= REP_MAX) ? REP_MAX : r_rep + 8'd1;
      end else begin
        w_rep_upd = 8'd1;
      end
      w_rep_nxt      = w_rep_upd;
      w_last_nxt     = trng_data;
      w_last_vld_nxt = 1'b1;
      w_trip         = (w_rep_upd >= REP_MAX);
    end else begin
      w_trip = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
          w_gidx_nxt  = w_pick;
          w_bcnt_nxt  = '0;
          w_state_nxt = S_COLLECT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (!req[r_gidx]) begin
          w_gnt_nxt   = '0;
          w_data_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_ptr_nxt   = w_gidx_inc;
          w_state_nxt = S_IDLE;
        end else if (trng_valid) begin
          w_data_nxt = (r_data << 8) | WORD_W'(trng_data);
          w_bcnt_nxt = r_bcnt + CW'(1);
          if (r_bcnt == LAST_BYTE) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = S_DELIVER;
          end else begin
            w_state_nxt = S_COLLECT;
          end
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_DELIVER: begin
        if (rnd_ready[r_gidx] || !req[r_gidx]) begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_data_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_ptr_nxt   = w_gidx_inc;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DELIVER;
        end
      end
      S_FAULT: begin
        // A fresh trip in the same cycle keeps the fault latched.
        if (fault_clr && !w_trip) begin
          w_fault_nxt    = 1'b0;
          w_rep_nxt      = 8'd0;
          w_last_vld_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_trip) begin
      w_state_nxt = S_FAULT;
      w_gnt_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_data_nxt  = '0;
      w_bcnt_nxt  = '0;
      w_fault_nxt = 1'b1;
    end else begin
      w_fault_nxt = w_fault_nxt;
    end
  end

  // State and output registers; outputs come straight from these flops.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_bcnt     <= '0;
      r_rep      <= 8'd0;
      r_last     <= 8'd0;
      r_last_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gidx     <= w_gidx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_rep      <= w_rep_nxt;
      r_last     <= w_last_nxt;
      r_last_vld <= w_last_vld_nxt;
    end
  end
endmodule

// File: tb/tb_trng_req_arbiter.sv
// Scoreboard bench for trng_req_arbiter: directed stimulus pushes expected words,
// a negedge monitor pops and compares them on every handshake.
module tb_trng_req_arbiter;
  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic [7:0]  trng_data = 8'd0;
  logic        trng_valid = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [3:0]  rnd_ready = 4'd0;
  logic        fault_clr = 1'b0;
  logic [3:0]  gnt;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        fault;

  int chk_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  trng_req_arbiter #(.N_REQ(4), .WORD_W(32), .REP_LIMIT(8)) dut (
    .clk(clk), .n_reset(n_reset), .trng_data(trng_data), .trng_valid(trng_valid),
    .req(req), .rnd_ready(rnd_ready), .fault_clr(fault_clr),
    .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] w4(input int b);
    return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
  endfunction

  task automatic do_reset();
    n_reset = 1'b1;
    req = 4'd0; rnd_ready = 4'd0; trng_valid = 1'b0; trng_data = 8'd0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_valid", 64'(rnd_valid), 64'd0);
    check("rst_data", 64'(rnd_data), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    @(posedge clk); #1;
    n_reset = 1'b0;
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!n_reset && rnd_valid && ((rnd_ready & gnt) != 4'd0)) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_unexpected: got gnt=%b data=%h expected no word", gnt, rnd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (gnt !== mon_e.g || rnd_data !== mon_e.d) begin
          err_cnt++;
          $display("FAIL sb_word: got gnt=%b data=%h expected gnt=%b data=%h",
                   gnt, rnd_data, mon_e.g, mon_e.d);
        end
      end
    end
  end

  initial begin
    // Single requester, bytes at full rate.
    do_reset();
    exp_q.push_back(exp_t'{4'b0001, 32'h11223344});
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      req        = (k <= 5) ? 4'b0001 : 4'b0000;
      trng_valid = (k >= 1 && k <= 4);
      trng_data  = 8'(k * 17);
      rnd_ready  = (k == 5) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (k == 1) begin
        check("t1_gnt", 64'(gnt), 64'h1);
        check("t1_valid_early", 64'(rnd_valid), 64'd0);
      end
      if (k == 4) check("t1_valid_t3", 64'(rnd_valid), 64'd0);
      if (k == 5) begin
        check("t1_valid_t4", 64'(rnd_valid), 64'd1);
        check("t1_data", 64'(rnd_data), 64'h11223344);
      end
      if (k == 6) begin
        check("t1_gnt_after", 64'(gnt), 64'd0);
        check("t1_valid_after", 64'(rnd_valid), 64'd0);
        check("t1_data_after", 64'(rnd_data), 64'd0);
      end
    end

    // All four requesting: round-robin order with one dead cycle per grant.
    do_reset();
    for (int j = 0; j < 5; j++) exp_q.push_back(exp_t'{4'(4'b0001 << (j % 4)), w4(8'h40 + 6 * j + 1)});
    for (int k = 0; k < 31; k++) begin
      @(posedge clk); #1;
      req = (k < 30) ? 4'b1111 : 4'b0000;
      rnd_ready = 4'b1111;
      trng_valid = 1'b1;
      trng_data = 8'(8'h40 + k);
      @(negedge clk);
    end
    trng_valid = 1'b0;

    // Consumer stalls in DELIVER while the stream keeps running.
    do_reset();
    exp_q.push_back(exp_t'{4'b0001, 32'h81828384});
    exp_q.push_back(exp_t'{4'b0001, 32'h91929394});
    for (int k = 0; k < 23; k++) begin
      @(posedge clk); #1;
      req = (k < 22) ? 4'b0001 : 4'b0000;
      rnd_ready = (k >= 15) ? 4'b0001 : 4'b0000;
      trng_valid = 1'b1;
      trng_data = 8'(8'h80 + k);
      @(negedge clk);
      if (k >= 5 && k <= 14) begin
        check("t3_hold_valid", 64'(rnd_valid), 64'd1);
        check("t3_hold_data", 64'(rnd_data), 64'h81828384);
      end
    end
    trng_valid = 1'b0;

    // Granted requester withdraws mid-collection.
    do_reset();
    exp_q.push_back(exp_t'{4'b0100, 32'hC5C6C7C8});
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      req = (k <= 2) ? 4'b0110 : ((k <= 9) ? 4'b0100 : 4'b0000);
      rnd_ready = 4'b0100;
      trng_valid = 1'b1;
      trng_data = 8'(8'hC0 + k);
      @(negedge clk);
      if (k == 1) check("t4_gnt1", 64'(gnt), 64'h2);
      if (k == 4) check("t4_abort", 64'(gnt), 64'd0);
      if (k == 5) check("t4_gnt2", 64'(gnt), 64'h4);
    end
    trng_valid = 1'b0;

    // Eight identical samples trip the fault during DELIVER; clear resumes.
    do_reset();
    exp_q.push_back(exp_t'{4'b0001, 32'h01020304});
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      req = (k <= 7) ? 4'b0001 : ((k <= 18) ? 4'b1111 : 4'b0000);
      rnd_ready = (k == 18) ? 4'b1111 : 4'b0000;
      fault_clr = (k == 12);
      trng_valid = (k <= 7) || (k >= 14 && k <= 17);
      trng_data = (k <= 7) ? 8'hA5 : 8'(k - 13);
      @(negedge clk);
      if (k == 7) begin
        check("t5_nofault_yet", 64'(fault), 64'd0);
        check("t5_pending", 64'(rnd_data), 64'hA5A5A5A5);
      end
      if (k == 8) begin
        check("t5_fault", 64'(fault), 64'd1);
        check("t5_gnt_off", 64'(gnt), 64'd0);
        check("t5_valid_off", 64'(rnd_valid), 64'd0);
        check("t5_data_off", 64'(rnd_data), 64'd0);
      end
      if (k >= 9 && k <= 12) begin
        check("t5_req_ignored", 64'(gnt), 64'd0);
        check("t5_fault_sticky", 64'(fault), 64'd1);
      end
      if (k == 13) check("t5_cleared", 64'(fault), 64'd0);
      if (k == 14) check("t5_resume_gnt", 64'(gnt), 64'h1);
    end
    fault_clr = 1'b0;
    trng_valid = 1'b0;

    // Seven repeats then a different sample stays healthy.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      trng_valid = (k <= 7);
      trng_data = (k <= 6) ? 8'hA5 : 8'h5A;
      @(negedge clk);
      if (k >= 8) check("t5_seven_ok", 64'(fault), 64'd0);
    end
    trng_valid = 1'b0;

    // Asynchronous reset in DELIVER clears outputs before the next edge.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      req = 4'b0001;
      rnd_ready = 4'b0000;
      trng_valid = 1'b1;
      trng_data = 8'(8'h60 + k);
      @(negedge clk);
      if (k == 6) check("t6_in_deliver", 64'(rnd_valid), 64'd1);
    end
    #2;
    n_reset = 1'b1;
    #1;
    check("t6_async_gnt", 64'(gnt), 64'd0);
    check("t6_async_valid", 64'(rnd_valid), 64'd0);
    check("t6_async_data", 64'(rnd_data), 64'd0);
    check("t6_async_fault", 64'(fault), 64'd0);
    @(posedge clk); #1;
    n_reset = 1'b0;
    req = 4'b1111;
    trng_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rr_restart", 64'(gnt), 64'h1);
    @(posedge clk); #1;
    req = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
